ff_wr_arbiter: RTL

//  Shares one FIFO write port (wr_only side of ff_intf) among NUM_REQ requesters.

---
 rtl/ff_wr_arbiter_if.sv | 37 +++
 rtl/ff_wr_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ff_wr_arbiter_if.sv
// Bundle between the write-port arbiter, its requesters and the shared FIFO write side.
// master is the arbiter's view; slave is the surrounding environment's view.
interface ff_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*DATA_W-1:0] req_wr_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        gnt_vec;
    logic                      busy;
    logic                      ff_full;
    logic                      ff_wr_en;
    logic [DATA_W-1:0]         ff_wr_data;

    modport master (
        input  req_wr_en,
        input  req_wr_data,
        input  ff_full,
        output req_ack,
        output gnt_vec,
        output busy,
        output ff_wr_en,
        output ff_wr_data
    );

    modport slave (
        output req_wr_en,
        output req_wr_data,
        output ff_full,
        input  req_ack,
        input  gnt_vec,
        input  busy,
        input  ff_wr_en,
        input  ff_wr_data
    );
endinterface

// File: rtl/ff_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// holding each grant for up to BURST_LEN accepted writes.
module ff_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic            clk_ir,
    input  logic            rst_ih,
    ff_wr_arbiter_if.master bus
);
    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
    localparam logic [PtrW-1:0] PtrRst   = PtrW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1) begin : g_param_check
        $error("ff_wr_arbiter: unsupported NUM_REQ/BURST_LEN");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] gnt_vec_q, gnt_vec_d;

    logic              busy;
    logic              owner_req;
    logic              acc;
    logic [DATA_W-1:0] owner_data;
    logic              pick_vld;
    logic [PtrW-1:0]   pick_idx;
    logic              grant_new;

    // Rotating priority: scan rr_ptr+1 .. rr_ptr+NUM_REQ, so the last owner ranks lowest.
    always_comb begin
        int unsigned idx;
        logic [PtrW-1:0] idx_w;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PtrW'(idx);
            if (!pick_vld && bus.req_wr_en[idx_w]) begin
                pick_vld = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    // rr_ptr always holds the current owner while granted.
    assign busy       = (state_q == StGrant);
    assign owner_req  = bus.req_wr_en[rr_ptr_q];
    assign owner_data = bus.req_wr_data[32'(rr_ptr_q) * DATA_W +: DATA_W];
    assign acc        = busy & owner_req & ~bus.ff_full;

    assign bus.busy       = busy;
    assign bus.gnt_vec    = gnt_vec_q;
    assign bus.ff_wr_en   = acc;
    assign bus.ff_wr_data = busy ? owner_data : '0;
    assign bus.req_ack    = acc ? gnt_vec_q : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_vec_d  = gnt_vec_q;
        grant_new  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_new = 1'b1;
                end
            end
            StGrant: begin
                if (acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (!owner_req || (acc && beat_cnt_q == LastBeat)) begin
                    if (pick_vld) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        gnt_vec_d  = '0;
                        beat_cnt_d = '0;
                    end
                end
            end
        endcase

        if (grant_new) begin
            state_d            = StGrant;
            rr_ptr_d           = pick_idx;
            beat_cnt_d         = '0;
            gnt_vec_d          = '0;
            gnt_vec_d[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state_q    <= StIdle;
            rr_ptr_q   <= PtrRst;
            beat_cnt_q <= '0;
            gnt_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_vec_q  <= gnt_vec_d;
        end
    end
endmodule
